pdp8_brk_arb: RTL

- Data-break (DMA) arbiter sharing the single I/O memory port (ram read/write request, done, ma, in, out) between two data-break devices, e.g. the RF08 disk and a second DMA peripheral.
- Sits between the device controllers in the I/O subsystem and the memory sequencer's io_ram interface.
- Grants the port to one requester at a time, round-robin, and holds the grant until the memory signals done.
- Recovers from a memory that never answers via a cycle timeout.

---
 rtl/pdp8_brk_arb.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pdp8_brk_arb.sv
// rtl/pdp8_brk_arb.sv - round-robin data-break arbiter for the shared I/O memory port
module pdp8_brk_arb #(
  parameter int TIMEOUT = 1023,
  parameter int MA_W    = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rq0_read_req,
  input  logic            rq0_write_req,
  input  logic [MA_W-1:0] rq0_ma,
  input  logic [11:0]     rq0_out,
  output logic            rq0_done,
  output logic [11:0]     rq0_in,
  input  logic            rq1_read_req,
  input  logic            rq1_write_req,
  input  logic [MA_W-1:0] rq1_ma,
  input  logic [11:0]     rq1_out,
  output logic            rq1_done,
  output logic [11:0]     rq1_in,
  output logic            ram_read_req,
  output logic            ram_write_req,
  output logic [MA_W-1:0] ram_ma,
  output logic [11:0]     ram_out,
  input  logic            ram_done,
  input  logic [11:0]     ram_in,
  output logic            brk_busy,
  output logic            timeout_err,
  input  logic            err_clr
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT0  = 2'd1;
  localparam logic [1:0] S_GRANT1  = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic            last_q, last_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            ram_rd_q, ram_rd_d;
  logic            ram_wr_q, ram_wr_d;
  logic [MA_W-1:0] ram_ma_q, ram_ma_d;
  logic [11:0]     ram_out_q, ram_out_d;
  logic            done0_q, done0_d;
  logic            done1_q, done1_d;
  logic [11:0]     in0_q, in0_d;
  logic [11:0]     in1_q, in1_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic act0, act1, pick1, sel_rd, sel_wr, fin;
  logic [11:0] fin_data;

  assign act0 = rq0_read_req | rq0_write_req;
  assign act1 = rq1_read_req | rq1_write_req;
  // On a tie the requester that was not granted last wins.
  assign pick1  = act1 & (~act0 | ~last_q);
  assign sel_wr = pick1 ? rq1_write_req : rq0_write_req;
  assign sel_rd = pick1 ? rq1_read_req  : rq0_read_req;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    ram_rd_d  = ram_rd_q;
    ram_wr_d  = ram_wr_q;
    ram_ma_d  = ram_ma_q;
    ram_out_d = ram_out_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    in0_d     = in0_q;
    in1_d     = in1_q;
    busy_d    = busy_q;
    err_d     = err_q & ~err_clr;
    fin       = 1'b0;
    fin_data  = 12'o7777;

    case (state_q)
      S_IDLE: begin
        if (act0 | act1) begin
          state_d   = pick1 ? S_GRANT1 : S_GRANT0;
          last_d    = pick1;
          cnt_d     = 16'd0;
          ram_wr_d  = sel_wr;
          ram_rd_d  = sel_rd & ~sel_wr;
          ram_ma_d  = pick1 ? rq1_ma : rq0_ma;
          ram_out_d = pick1 ? rq1_out : rq0_out;
          busy_d    = 1'b1;
        end
      end
      S_GRANT0, S_GRANT1: begin
        if (ram_done) begin
          fin      = 1'b1;
          fin_data = ram_in;
        end else if (cnt_q == CNT_LAST) begin
          fin   = 1'b1;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
        if (fin) begin
          state_d  = S_RELEASE;
          ram_rd_d = 1'b0;
          ram_wr_d = 1'b0;
          busy_d   = 1'b0;
          if (state_q == S_GRANT1) begin
            done1_d = 1'b1;
            if (ram_rd_q) in1_d = fin_data;
          end else begin
            done0_d = 1'b1;
            if (ram_rd_q) in0_d = fin_data;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      cnt_q     <= 16'd0;
      ram_rd_q  <= 1'b0;
      ram_wr_q  <= 1'b0;
      ram_ma_q  <= '0;
      ram_out_q <= 12'd0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      in0_q     <= 12'd0;
      in1_q     <= 12'd0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      ram_rd_q  <= ram_rd_d;
      ram_wr_q  <= ram_wr_d;
      ram_ma_q  <= ram_ma_d;
      ram_out_q <= ram_out_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      in0_q     <= in0_d;
      in1_q     <= in1_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign ram_read_req  = ram_rd_q;
  assign ram_write_req = ram_wr_q;
  assign ram_ma        = ram_ma_q;
  assign ram_out       = ram_out_q;
  assign rq0_done      = done0_q;
  assign rq1_done      = done1_q;
  assign rq0_in        = in0_q;
  assign rq1_in        = in1_q;
  assign brk_busy      = busy_q;
  assign timeout_err   = err_q;

endmodule
